fixed_acc_seq: RTL and testbench
================================

Name: fixed_acc_seq

Overview:
Sequencer that drives one shared 18-bit sign-magnitude adder (the existing fixed-point adder) to reduce a serial stream of LEN products into one sum, seeded with a bias. It sits between a convolution/FC multiplier array and the activation/pooling stage. One start produces one result.

Parameters:
LEN, 25, number of input beats accumulated per job (25 = 5x5 kernel); legal range 1..2**CNT_W.
CNT_W, 5, beat-counter width.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle job request; sampled only in IDLE
bias  input  18  sign-magnitude seed, captured on accepted start
in_valid  input  1  input beat valid
in_ready  output  1  high while in ACC
in_data  input  18  sign-magnitude operand: bit17 sign (1 = negative), bits16:0 magnitude
out_valid  output  1  result valid, held until out_ready
out_ready  input  1  downstream accept
out_data  output  18  accumulated sign-magnitude result
out_ovf  output  1  sticky overflow flag for this job, valid with out_valid
busy  output  1  high in ACC and DONE

Behaviour:
- Reset: reset is synchronous and active-low, on rst_n; one clock, clk. On a rising clk edge with rst_n=0: state=IDLE, acc=0, cnt=0, ovf=0. Outputs in reset: in_ready=0, out_valid=0, out_data=0, out_ovf=0, busy=0.
- Reset while in ACC or DONE aborts the job. The partial sum is discarded and no result is produced.
- States: IDLE, ACC, DONE.
- IDLE:
  - start=1 -> acc<=bias (-0 normalised to +0), cnt<=0, ovf<=0, go to ACC.
  - start=0 -> stay in IDLE.
- ACC:
  - in_ready=1. A beat is accepted on in_valid & in_ready.
  - Per accepted beat: acc <= adder(acc, in_data), cnt <= cnt+1.
  - When the accepted beat has cnt==LEN-1, go to DONE.
  - No accepted beat -> hold acc and cnt. Gaps in in_valid are legal.
  - start is ignored in ACC and DONE.
- DONE:
  - out_valid=1, out_data=acc, out_ovf=ovf, in_ready=0.
  - out_ready=1 -> go to IDLE the next cycle. out_valid is stable until that handshake.
- Latency: out_valid rises on the first cycle after the last beat is accepted. With back-to-back beats, the minimum job is 1 (start) + LEN + 1 cycles. DONE->IDLE costs one cycle, so a new start is sampled no earlier than the cycle after the out handshake.
- Arithmetic: combinational adder, same-cycle result, registered in acc.
  - Same signs: magnitudes add, sign is kept.
  - Different signs: the larger magnitude minus the smaller, with the sign of the larger.
  - Equal magnitudes with different signs: the result is +0. The sequencer forces the sign bit to 0 whenever the magnitude is 0, and applies the same rule to bias and out_data.
- Overflow: computed in parallel as an 18-bit sum {1'b0,acc[16:0]}+{1'b0,in_data[16:0]} on same-sign beats.
  - If carry is set: acc magnitude saturates to 17'h1FFFF with the sign kept, and ovf<=1.
  - ovf is sticky for the job and cleared only on start or reset.
  - After saturation, later opposite-sign beats subtract normally from 17'h1FFFF.
- LEN=1: exactly one beat, then DONE.

Decomposition:
- Shared package: the sign-magnitude width constant (18), SIGN_BIT=17, MAG_W=17, MAG_MAX=17'h1FFFF, and the state encoding (IDLE=2'd0, ACC=2'd1, DONE=2'd2).
- Sub-module: one instance of the existing fixed-point adder. The sequencer adds the saturation mux, -0 normalisation, counter and FSM around it.

Test Plan:
- Basic sum, LEN=4: bias=+1 (18'h00001), beats +3, 18'h20005 (-5), +10, 18'h20002 (-2) -> out_data=18'h00007, out_ovf=0, out_valid exactly 1 cycle after the 4th beat.
- Cancellation to zero: bias=18'h20004, beats +4, 0, 0, 0 -> out_data=18'h00000 (+0, never 18'h20000), out_ovf=0.
- Saturation, LEN=4: bias=17'h1FFF0, beats +16'h0020, 18'h20010, 0, 0 -> saturate at 1FFFF, then 1FFEF: out_data=18'h1FFEF, out_ovf=1. A following job with small values -> out_ovf=0.
- Handshake: in_valid toggles 1,0,0,1,... and out_ready is held 0 for 5 cycles -> sum unchanged by the gaps; out_data/out_valid stable for the 5 cycles; IDLE one cycle after out_ready=1; start pulsed during ACC/DONE is ignored.
- Reset mid-job: rst_n=0 for 1 cycle after 2 of 4 beats -> all outputs 0 on the next edge, then a fresh job with bias=0 and beats +1 ×4 -> out_data=18'h00004.
- LEN=1, back-to-back jobs: start, one beat 18'h20003 -> 18'h20003. Immediate next start after the out handshake -> second result correct, no state leaks between jobs.

Source files
------------

// File: rtl/fixed_acc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fixed_acc_seq_pkg
// Brief    : Shared sign-magnitude constants, FSM encoding and -0 helper.
// Revision : 1.0
// ============================================================================
package fixed_acc_seq_pkg;

    localparam int c_SM_W     = 18;
    localparam int c_SIGN_BIT = 17;
    localparam int c_MAG_W    = 17;
    localparam logic [c_MAG_W-1:0] c_MAG_MAX = 17'h1FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A zero magnitude is always reported as +0.
    function automatic logic [c_SM_W-1:0] sm_norm(input logic [c_SM_W-1:0] v);
        sm_norm = (v[c_MAG_W-1:0] == '0) ? '0 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_acc_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : fixed_acc_seq_adder
// Brief    : Combinational 18-bit sign-magnitude adder (magnitude wraps).
// Revision : 1.0
// ============================================================================
module fixed_acc_seq_adder
    import fixed_acc_seq_pkg::*;
(
    input  logic [c_SM_W-1:0] a,
    input  logic [c_SM_W-1:0] b,
    output logic [c_SM_W-1:0] sum
);

    logic               w_a_sign;
    logic               w_b_sign;
    logic [c_MAG_W-1:0] w_a_mag;
    logic [c_MAG_W-1:0] w_b_mag;
    logic [c_MAG_W-1:0] w_mag;
    logic               w_sign;

    assign w_a_sign = a[c_SIGN_BIT];
    assign w_b_sign = b[c_SIGN_BIT];
    assign w_a_mag  = a[c_MAG_W-1:0];
    assign w_b_mag  = b[c_MAG_W-1:0];

    always_comb begin
        w_mag  = '0;
        w_sign = 1'b0;
        if (w_a_sign == w_b_sign) begin
            w_mag  = w_a_mag + w_b_mag;
            w_sign = w_a_sign;
        end else if (w_a_mag >= w_b_mag) begin
            w_mag  = w_a_mag - w_b_mag;
            w_sign = w_a_sign;
        end else begin
            w_mag  = w_b_mag - w_a_mag;
            w_sign = w_b_sign;
        end
    end

    assign sum = {w_sign, w_mag};

endmodule
`default_nettype wire

// File: rtl/fixed_acc_seq.sv
`default_nettype none
// ============================================================================
// Module   : fixed_acc_seq
// Brief    : Bias-seeded LEN-beat sign-magnitude accumulator around one adder.
// Revision : 1.0
// ============================================================================
module fixed_acc_seq
    import fixed_acc_seq_pkg::*;
#(
    parameter int LEN   = 25,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [c_SM_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [c_SM_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [c_SM_W-1:0] out_data,
    output logic              out_ovf,
    output logic              busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_SM_W-1:0]  r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic               w_beat;
    logic               w_last;
    logic               w_same;
    logic [c_MAG_W:0]   w_mag_sum;
    logic               w_carry;
    logic [c_SM_W-1:0]  w_add_sum;
    logic [c_SM_W-1:0]  w_acc_nxt;

    fixed_acc_seq_adder u_adder (
        .a   (r_acc),
        .b   (in_data),
        .sum (w_add_sum)
    );

    assign w_beat = in_valid & in_ready;
    assign w_last = (r_cnt == CNT_W'(LEN - 1));

    // Overflow is detected beside the adder so its wrapped sum can be replaced.
    assign w_same    = (r_acc[c_SIGN_BIT] == in_data[c_SIGN_BIT]);
    assign w_mag_sum = {1'b0, r_acc[c_MAG_W-1:0]} + {1'b0, in_data[c_MAG_W-1:0]};
    assign w_carry   = w_same && (w_mag_sum > {1'b0, c_MAG_MAX});
    assign w_acc_nxt = w_carry ? {r_acc[c_SIGN_BIT], c_MAG_MAX} : sm_norm(w_add_sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)           w_state_nxt = ACC;
            ACC:     if (w_beat && w_last) w_state_nxt = DONE;
            DONE:    if (out_ready)       w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_acc <= sm_norm(bias);
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_carry) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == ACC);
    assign busy      = (r_state == ACC) || (r_state == DONE);
    assign out_valid = (r_state == DONE);
    assign out_data  = out_valid ? sm_norm(r_acc) : '0;
    assign out_ovf   = out_valid & r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fixed_acc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_acc_seq
// Brief    : Directed self-checking bench for fixed_acc_seq (LEN=4 and LEN=1).
// Revision : 1.0
// ============================================================================
module tb_fixed_acc_seq;

    logic        clk;
    logic        rst_n;

    logic        start4, in_valid4, in_ready4, out_valid4, out_ready4, out_ovf4, busy4;
    logic [17:0] bias4, in_data4, out_data4;
    logic        start1, in_valid1, in_ready1, out_valid1, out_ready1, out_ovf1, busy1;
    logic [17:0] bias1, in_data1, out_data1;

    int n_checks = 0;
    int n_errors = 0;

    fixed_acc_seq #(.LEN(4), .CNT_W(5)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .bias      (bias4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .out_ovf   (out_ovf4),
        .busy      (busy4)
    );

    fixed_acc_seq #(.LEN(1), .CNT_W(5)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .bias      (bias1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .out_ovf   (out_ovf1),
        .busy      (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job4(input string tag, input logic [17:0] b,
                            input logic [17:0] d0, input logic [17:0] d1,
                            input logic [17:0] d2, input logic [17:0] d3,
                            input logic [17:0] exp_data, input logic exp_ovf);
        logic [17:0] beats [4];
        beats[0] = d0; beats[1] = d1; beats[2] = d2; beats[3] = d3;
        start4 = 1'b1;
        bias4  = b;
        wait_clk();
        start4 = 1'b0;
        chk({tag, ".in_ready"}, 32'(in_ready4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1;
            in_data4  = beats[i];
            wait_clk();
            chk({tag, ".out_valid"}, 32'(out_valid4), (i == 3) ? 32'd1 : 32'd0);
        end
        in_valid4 = 1'b0;
        in_data4  = '0;
        chk({tag, ".data"}, 32'(out_data4), 32'(exp_data));
        chk({tag, ".ovf"}, 32'(out_ovf4), 32'(exp_ovf));
        out_ready4 = 1'b1;
        wait_clk();
        out_ready4 = 1'b0;
        chk({tag, ".idle"}, 32'({out_valid4, busy4}), 32'd0);
    endtask

    initial begin
        logic pat [7];
        logic [17:0] nxt;

        rst_n = 1'b0;
        start4 = 0; bias4 = '0; in_valid4 = 0; in_data4 = '0; out_ready4 = 0;
        start1 = 0; bias1 = '0; in_valid1 = 0; in_data1 = '0; out_ready1 = 0;
        wait_clk();
        wait_clk();
        chk("rst.dut4", 32'({in_ready4, out_valid4, out_ovf4, busy4}), 32'd0);
        chk("rst.data4", 32'(out_data4), 32'd0);
        chk("rst.dut1", 32'({in_ready1, out_valid1, out_ovf1, busy1}), 32'd0);
        rst_n = 1'b1;
        wait_clk();

        // 1 + 3 - 5 + 10 - 2 = 7
        run_job4("basic", 18'h00001, 18'h00003, 18'h20005, 18'h0000A, 18'h20002, 18'h00007, 1'b0);
        // -4 + 4 must give +0
        run_job4("cancel", 18'h20004, 18'h00004, 18'h00000, 18'h00000, 18'h00000, 18'h00000, 1'b0);
        // saturate to 1FFFF, then subtract 0x10
        run_job4("sat", 18'h1FFF0, 18'h00020, 18'h20010, 18'h00000, 18'h00000, 18'h1FFEF, 1'b1);
        run_job4("post_sat", 18'h00002, 18'h00001, 18'h00001, 18'h20001, 18'h00001, 18'h00004, 1'b0);

        // Handshake: gapped beats +2,+3,+4,+5 with start pulses in ACC/DONE
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1; pat[6] = 1;
        nxt = 18'h00002;
        start4 = 1'b1;
        bias4  = 18'h00000;
        wait_clk();
        bias4 = 18'h00100;
        for (int i = 0; i < 7; i++) begin
            start4    = (i == 1);
            in_valid4 = pat[i];
            in_data4  = pat[i] ? nxt : 18'h0FFFF;
            wait_clk();
            if (pat[i]) nxt = nxt + 18'd1;
        end
        in_valid4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start4 = (i == 2);
            chk("hs.hold_valid", 32'(out_valid4), 32'd1);
            chk("hs.hold_data", 32'(out_data4), 32'h0000E);
            chk("hs.in_ready", 32'(in_ready4), 32'd0);
            wait_clk();
        end
        start4 = 1'b0;
        out_ready4 = 1'b1;
        wait_clk();
        out_ready4 = 1'b0;
        chk("hs.idle", 32'({out_valid4, busy4, in_ready4}), 32'd0);
        wait_clk();
        chk("hs.stay_idle", 32'(busy4), 32'd0);

        // Reset after 2 of 4 beats discards the job
        start4 = 1'b1;
        bias4  = 18'h00064;
        wait_clk();
        start4 = 1'b0;
        in_valid4 = 1'b1;
        in_data4  = 18'h00005;
        wait_clk();
        wait_clk();
        in_valid4 = 1'b0;
        rst_n = 1'b0;
        wait_clk();
        rst_n = 1'b1;
        chk("midrst.ctl", 32'({in_ready4, out_valid4, out_ovf4, busy4}), 32'd0);
        chk("midrst.data", 32'(out_data4), 32'd0);
        run_job4("after_rst", 18'h00000, 18'h00001, 18'h00001, 18'h00001, 18'h00001, 18'h00004, 1'b0);

        // LEN=1 back-to-back jobs
        start1 = 1'b1;
        bias1  = 18'h00000;
        wait_clk();
        start1 = 1'b0;
        in_valid1 = 1'b1;
        in_data1  = 18'h20003;
        wait_clk();
        in_valid1 = 1'b0;
        chk("len1.valid", 32'(out_valid1), 32'd1);
        chk("len1.data", 32'(out_data1), 32'h20003);
        out_ready1 = 1'b1;
        wait_clk();
        out_ready1 = 1'b0;
        start1 = 1'b1;
        bias1  = 18'h00005;
        wait_clk();
        start1 = 1'b0;
        chk("len1b.accept", 32'(in_ready1), 32'd1);
        in_valid1 = 1'b1;
        in_data1  = 18'h00002;
        wait_clk();
        in_valid1 = 1'b0;
        chk("len1b.data", 32'(out_data1), 32'h00007);
        chk("len1b.ovf", 32'(out_ovf1), 32'd0);
        out_ready1 = 1'b1;
        wait_clk();
        out_ready1 = 1'b0;

        // -0 bias plus -0 beat must report +0
        start1 = 1'b1;
        bias1  = 18'h20000;
        wait_clk();
        start1 = 1'b0;
        in_valid1 = 1'b1;
        in_data1  = 18'h20000;
        wait_clk();
        in_valid1 = 1'b0;
        chk("len1.negzero", 32'(out_data1), 32'h00000);
        out_ready1 = 1'b1;
        wait_clk();
        out_ready1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
